// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment pattern reader: the active-low
// digit patterns, the reader FSM states and the pattern decode function.
package seg7_pkg;

  localparam logic [7:0] SEG7_D0    = 8'hC0;
  localparam logic [7:0] SEG7_D1    = 8'hF9;
  localparam logic [7:0] SEG7_D2    = 8'hA4;
  localparam logic [7:0] SEG7_D3    = 8'hB0;
  localparam logic [7:0] SEG7_D4    = 8'h99;
  localparam logic [7:0] SEG7_D5    = 8'h92;
  localparam logic [7:0] SEG7_D6    = 8'h82;
  localparam logic [7:0] SEG7_D7    = 8'hF8;
  localparam logic [7:0] SEG7_BLANK = 8'hFF;

  typedef enum logic {WATCH, PRESENT} state_t;

  typedef struct packed {
    logic [2:0] value;
    logic       blank;
    logic       error;
  } dec_t;

  // Map a segment pattern to {value, blank, error}. Every table entry has
  // DP dark (bit7=1), so any pattern with DP lit falls into the error case.
  function automatic dec_t seg7_decode(input logic [7:0] pat);
    dec_t d;
    d = '0;
    case (pat)
      SEG7_D0:    d.value = 3'd0;
      SEG7_D1:    d.value = 3'd1;
      SEG7_D2:    d.value = 3'd2;
      SEG7_D3:    d.value = 3'd3;
      SEG7_D4:    d.value = 3'd4;
      SEG7_D5:    d.value = 3'd5;
      SEG7_D6:    d.value = 3'd6;
      SEG7_D7:    d.value = 3'd7;
      SEG7_BLANK: d.blank = 1'b1;
      default:    d.error = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Samples the segment bus and flags when the sampled pattern has been
// constant for STABLE_CYCLES consecutive samples.
module seg7_stable_filter
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  output logic [7:0] s_q,
  output logic       stable
);

  localparam logic [7:0] LIMIT = 8'(STABLE_CYCLES);

  logic [7:0] cnt;

  // Sample register and run-length counter. The incoming sample is compared
  // with the one being replaced, so cnt always describes the run that s_q
  // belongs to; a fresh value starts a run of length 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q <= SEG7_BLANK;
      cnt <= 8'd0;
    end else begin
      s_q <= seg_in;
      if (seg_in == s_q) begin
        if (cnt < LIMIT) cnt <= cnt + 8'd1;
      end else begin
        cnt <= 8'd1;
      end
    end
  end

  assign stable = (cnt == LIMIT);

endmodule

// File: rtl/seg7_pattern_reader.sv
// Reads an active-low seven-segment bus, waits for it to settle and reports
// each new stable pattern as a decoded digit on a valid/ready interface.
module seg7_pattern_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_value,
  output logic       out_blank,
  output logic       out_error,
  output logic       out_lost
);

  logic [7:0] s_q;
  logic       stable;
  dec_t       dec;

  state_t     state;
  logic [7:0] last_rep;
  logic [7:0] cand;
  logic       cand_vld;
  logic       pend_lost;

  seg7_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .seg_in(seg_in),
    .s_q   (s_q),
    .stable(stable)
  );

  assign dec = seg7_decode(s_q);

  // Report FSM. While a report waits, a second distinct stable pattern
  // (neither the reported one nor the first candidate seen since) means an
  // intermediate pattern will never be reported; that is remembered in
  // pend_lost and attached to the next report. Acceptance takes priority
  // over a new pattern, which is then picked up from WATCH on the next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= WATCH;
      out_valid <= 1'b0;
      out_value <= 3'd0;
      out_blank <= 1'b0;
      out_error <= 1'b0;
      out_lost  <= 1'b0;
      last_rep  <= SEG7_BLANK;
      cand      <= SEG7_BLANK;
      cand_vld  <= 1'b0;
      pend_lost <= 1'b0;
    end else begin
      case (state)
        WATCH: begin
          if (stable && (s_q != last_rep)) begin
            out_value <= dec.value;
            out_blank <= dec.blank;
            out_error <= dec.error;
            out_lost  <= pend_lost;
            pend_lost <= 1'b0;
            last_rep  <= s_q;
            cand_vld  <= 1'b0;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (stable && (s_q != last_rep) && (!cand_vld || (s_q != cand))) begin
            if (cand_vld) pend_lost <= 1'b1;
            cand     <= s_q;
            cand_vld <= 1'b1;
          end
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= WATCH;
          end
        end
        default: state <= WATCH;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_pattern_reader.sv
// Randomized scoreboard bench for seg7_pattern_reader. A run-length reference
// model predicts each report and the edge it appears on; a negedge monitor
// checks every rising out_valid, field stability while held, and the
// mandatory idle cycle after each acceptance.
module tb_seg7_pattern_reader;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_in = 8'hFF;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [2:0] out_value;
  logic       out_blank;
  logic       out_error;
  logic       out_lost;

  always #5 clk = ~clk;

  seg7_pattern_reader #(.STABLE_CYCLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_in   (seg_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_value(out_value),
    .out_blank(out_blank),
    .out_error(out_error),
    .out_lost (out_lost)
  );

  typedef struct {
    logic [2:0] v;
    logic       b;
    logic       e;
    logic       l;
    int         edge_no;
  } rep_t;

  rep_t exp_q[$];
  int total = 0;
  int bad = 0;
  int ecount = 0;

  logic [7:0] digits [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  // reference model state
  logic [7:0] m_s = 8'hFF, m_last = 8'hFF, m_cand = 8'hFF;
  int         m_run = 0;
  bit         m_busy = 0, m_cand_vld = 0, m_lost = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // One clock edge of the specified behaviour, applied to the inputs
  // present at that edge.
  task automatic model_edge(input logic [7:0] seg, input logic rdy, input logic rst);
    bit   stable;
    bit   found;
    rep_t r;
    if (!rst) begin
      m_s = 8'hFF; m_run = 0; m_last = 8'hFF; m_busy = 0;
      m_cand_vld = 0; m_lost = 0;
      return;
    end
    stable = (m_run >= N);
    if (!m_busy) begin
      if (stable && m_s != m_last) begin
        r.v = 3'd0; r.b = 1'b0; r.e = 1'b0; found = 0;
        for (int i = 0; i < 8; i++)
          if (digits[i] == m_s) begin r.v = 3'(i); found = 1; end
        if (m_s == 8'hFF) r.b = 1'b1;
        else if (!found) r.e = 1'b1;
        r.l = m_lost;
        r.edge_no = ecount;
        exp_q.push_back(r);
        m_lost = 0; m_last = m_s; m_busy = 1; m_cand_vld = 0;
      end
    end else begin
      if (stable && m_s != m_last && (!m_cand_vld || m_s != m_cand)) begin
        if (m_cand_vld) m_lost = 1;
        m_cand = m_s;
        m_cand_vld = 1;
      end
      if (rdy) m_busy = 0;
    end
    m_run = (seg == m_s) ? m_run + 1 : 1;
    m_s = seg;
  endtask

  task automatic step(input logic [7:0] seg, input logic rdy, input logic rst);
    seg_in = seg;
    out_ready = rdy;
    rst_n = rst;
    @(posedge clk);
    ecount++;
    model_edge(seg, rdy, rst);
    #1;
  endtask

  task automatic hold(input logic [7:0] seg, input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(seg, rdy, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_value"}, out_value, 0);
    chk({tag, "_blank"}, out_blank, 0);
    chk({tag, "_error"}, out_error, 0);
    chk({tag, "_lost"},  out_lost,  0);
  endtask

  // monitor
  logic       pv = 1'b0, prev_hs = 1'b0;
  logic [2:0] h_v;
  logic       h_b, h_e, h_l;

  always @(negedge clk) begin
    rep_t r;
    if (prev_hs && out_valid) chk("idle_after_accept", out_valid, 0);
    if (out_valid && !pv) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_report", 1, 0);
      end else begin
        r = exp_q.pop_front();
        chk("rep_edge",  ecount,    r.edge_no);
        chk("rep_value", out_value, r.v);
        chk("rep_blank", out_blank, r.b);
        chk("rep_error", out_error, r.e);
        chk("rep_lost",  out_lost,  r.l);
      end
      h_v = out_value; h_b = out_blank; h_e = out_error; h_l = out_lost;
    end else if (out_valid && pv && !prev_hs) begin
      chk("held_fields", {out_value, out_blank, out_error, out_lost}, {h_v, h_b, h_e, h_l});
    end
    if (out_valid && !pv && exp_q.size() > 0 && exp_q[0].edge_no < ecount)
      chk("late_report", exp_q[0].edge_no, ecount);
    pv = out_valid;
    prev_hs = out_valid && out_ready;
  end

  initial begin
    int len;
    logic [7:0] p;
    logic rdy;

    // reset and idle blank display
    step(8'hFF, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
    chk_all_zero("reset");
    for (int i = 0; i < 20; i++) begin
      step(8'hFF, 1'b1, 1'b1);
      chk("idle_blank_valid", out_valid, 0);
    end

    // basic digit, glitch rejection, blank report
    hold(8'hA4, 1'b1, 8);
    hold(8'hFF, 1'b1, 8);
    hold(8'h99, 1'b1, 3);
    hold(8'hFF, 1'b1, 6);
    hold(8'h99, 1'b1, 8);

    // back-pressure with a superseded pattern
    hold(8'hF8, 1'b0, 8);
    hold(8'hC0, 1'b0, 6);
    hold(8'h92, 1'b0, 6);
    hold(8'h92, 1'b1, 8);
    hold(8'hF8, 1'b1, 8);

    // DP lit, then blank
    hold(8'h7F, 1'b1, 8);
    hold(8'hFF, 1'b1, 8);

    // reset while a report is pending
    hold(8'hA4, 1'b0, 6);
    chk("pre_reset_valid", out_valid, 1);
    step(8'hA4, 1'b1, 1'b0);
    chk_all_zero("mid_reset");
    for (int i = 0; i < 10; i++) begin
      step(8'hFF, 1'b1, 1'b1);
      chk("post_reset_blank_valid", out_valid, 0);
    end

    // randomized traffic
    for (int s = 0; s < 400; s++) begin
      case ($urandom_range(0, 19))
        0, 1, 2:  p = 8'hFF;
        3, 4, 5:  p = 8'($urandom());
        default:  p = digits[$urandom_range(0, 7)];
      endcase
      len = $urandom_range(1, 7);
      if ($urandom_range(0, 99) == 0) step(p, 1'b1, 1'b0);
      for (int i = 0; i < len; i++) begin
        rdy = ($urandom_range(0, 9) < 6);
        step(p, rdy, 1'b1);
      end
    end

    // drain
    hold(seg_in, 1'b1, 12);
    @(negedge clk);
    chk("leftover_reports", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_pattern_reader.md
# seg7_pattern_reader

Reads an 8-bit active-low seven-segment drive bus, waits for the pattern to settle, and decodes it back to a 3-bit digit value. It then presents each new stable digit on a valid/ready output. It sits on the checker side of the taillight display path: it is the reader of the segment patterns the display decoder writes. It is used for self-test and loopback verification on the DE10-Lite.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive equal samples required before a pattern is accepted; legal range 1..255.

Ports:
- clk  in  1  system clock; one clock domain only.
- rst_n  in  1  synchronous, active-low reset.
- seg_in  in  8  segment bus, active-low; bit7 = DP, bit6..0 = g..a.
- out_valid  out  1  a report is pending.
- out_ready  in  1  consumer accepts the report.
- out_value  out  3  decoded digit 0..7; 0 when blank or error.
- out_blank  out  1  pattern was 8'hFF (all segments off).
- out_error  out  1  pattern is not in the decode table, or DP is lit.
- out_lost  out  1  at least one distinct stable pattern was superseded while the previous report waited.

## Operation
- seg_in is registered into s_q on every clk edge. All other logic uses s_q only.
- Stability counter cnt (8 bit):
  - If s_q equals its previous value, cnt increments, saturating at STABLE_CYCLES.
  - Otherwise cnt reloads to 1.
- A pattern is stable when cnt == STABLE_CYCLES.
- last_rep (8 bit) holds the last reported pattern. It resets to 8'hFF, so a blank display after reset produces no report.
- Decode table (pattern to value):
  - C0→0, F9→1, A4→2, B0→3, 99→4, 92→5, 82→6, F8→7.
  - FF gives out_blank=1.
  - Any other pattern gives out_error=1. This includes every pattern with bit7=0.
- State machine:
  - WATCH: out_valid=0. If s_q is stable and s_q ≠ last_rep, load the output registers from the decode, set last_rep=s_q, and go to PRESENT.
  - PRESENT: out_valid=1. All out_* fields are held constant.
    - Stability tracking continues.
    - If a stable pattern appears that differs from both last_rep and the currently tracked candidate, set pend_lost.
    - When out_valid & out_ready, return to WATCH. out_lost for the next report is taken from pend_lost, and pend_lost is then cleared.
- After acceptance, a pattern that is already stable and differs from last_rep is reported on the next edge. No re-settling is required.
- A pattern that returns to the last_rep value is not re-reported.

## Timing
- Reset (rst_n=0 at an edge) sets the following, overriding any in-flight handshake:
  - out_valid=0, out_value=0, out_blank=0, out_error=0, out_lost=0.
  - cnt=0, last_rep=FF, pend_lost=0, state WATCH, s_q=FF.
- Latency: seg_in changes before edge E0 and is then held. out_valid rises after edge E0+STABLE_CYCLES. With the default, that is 4 cycles.
- Glitch rejection: any change on seg_in shorter than STABLE_CYCLES samples produces no report.
- Handshake:
  - out_valid stays high until it is sampled together with out_ready.
  - out_ready has no effect while out_valid=0.
  - Back-to-back reports are allowed, with a minimum of one cycle of out_valid=0 between them.
- Simultaneous events: acceptance and a new stable pattern on the same edge mean the acceptance wins. The new pattern is reported on the following edge.
- STABLE_CYCLES=1: every sampled change that differs from last_rep is reported 1 edge after sampling.

## Structure
- A shared package seg7_pkg holds:
  - the eight digit pattern constants and SEG7_BLANK=8'hFF;
  - the state enum {WATCH, PRESENT};
  - a function that maps a pattern to {value, blank, error}.
- One natural sub-module, seg7_stable_filter, contains the sample register, the counter, and the stable output. The top-level module holds the FSM, last_rep, pend_lost and the output registers.

## Test plan
- After reset, hold seg_in=FF with out_ready=1 → out_valid stays 0 for 20 cycles; all outputs 0.
- Drive seg_in=A4 at E0 and hold, with out_ready=1 → out_valid=1 after E0+4 for exactly 1 cycle, with out_value=2, out_blank=0, out_error=0.
- Glitch: FF→99 for 3 cycles, then back to FF → no report. Then 99 held → report with value 4.
- Hold out_ready=0 after a report of 7 (F8). Drive C0 stable, then 92 stable → out_valid and the value-7 fields stay constant. Raise out_ready → next report is 5 with out_lost=1, and the following report has out_lost=0.
- Drive seg_in=7F (DP lit) stable → report with out_error=1 and out_value=0. Then FF stable → report with out_blank=1.
- Assert rst_n=0 for 1 edge while out_valid=1 → all outputs 0 on that edge. A stable FF afterwards gives no report.
